sub2_and_clip_reg: RTL and testbench
====================================

Name: sub2_and_clip_reg

Overview:
Registered, strobe-qualified saturating subtractor: out = clip(in1 - in2) on signed two's-complement samples. It is the subtractive counterpart of the team's add-and-clip datapath element, used for error terms, DC-offset removal and stream differencing. It runs a 2-stage pipeline and reports clip events: per-sample hi/lo flags, a sticky flag and a saturating event counter.

Parameters:
WIDTH, 16, sample width in bits (signed two's complement), >= 2
CNT_WIDTH, 16, clip event counter width, >= 1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
in1  input  WIDTH  minuend, signed
in2  input  WIDTH  subtrahend, signed
strobe_in  input  1  in1/in2 valid this cycle
clr  input  1  clears clip_sticky and clip_cnt
diff  output  WIDTH  clipped difference, registered
strobe_out  output  1  diff valid this cycle, single-cycle pulse per accepted sample
clip_hi  output  1  sample on diff saturated positive; valid with strobe_out
clip_lo  output  1  sample on diff saturated negative; valid with strobe_out
clip_sticky  output  1  set on any clipped output sample until clr
clip_cnt  output  CNT_WIDTH  count of clipped output samples, saturating (only with feature)

Behaviour:
- Reset (rst=1 at a clock edge): diff=0, strobe_out=0, clip_hi=0, clip_lo=0, clip_sticky=0, clip_cnt=0. Both pipeline valid bits are cleared, so in-flight samples are discarded and never produce strobe_out. rst has priority over all other inputs.
- Stage 1, on strobe_in=1:
  - Register raw = sext(in1) - sext(in2) at WIDTH+1 bits. The result is exact, with no wrap.
  - Set v1=1; otherwise v1=0. The raw register holds when not strobed.
- Stage 2, on v1=1:
  - raw > 2^(WIDTH-1)-1: diff = MAX (0x7FFF for 16), clip_hi=1.
  - raw < -2^(WIDTH-1): diff = MIN (0x8000 for 16), clip_lo=1.
  - Otherwise diff = raw[WIDTH-1:0], clip_hi=clip_lo=0.
  - strobe_out=1.
- Stage 2, on v1=0: strobe_out=0, clip_hi=clip_lo=0, diff holds its last value.
- Latency: strobe_in at edge n gives strobe_out at edge n+2. Throughput is 1 sample per clock; back-to-back strobes are fully supported with no bubbles.
- clip_hi and clip_lo are never both 1. Exact MAX or MIN results that are not clipped do not assert the flags.
- clip_sticky:
  - Set on any cycle with strobe_out & (clip_hi | clip_lo), as a registered update on the following edge.
  - clr=1 clears it.
  - clr and a new clip event in the same cycle: the set wins; the event is never lost.
- clip_cnt:
  - Increments by 1 per clip event, saturates at 2^CNT_WIDTH-1 with no wrap.
  - clr=1 loads 0; clr with a simultaneous event loads 1.
- clr does not affect the datapath or strobe pipeline.
- strobe_in while rst=1 is ignored.

Optional Feature:
Macro SUB2_CLIP_CNT_EN.
- Defined: clip_cnt counter present as described.
- Undefined: counter logic is removed and the clip_cnt port still exists, tied to 0. The port list is unchanged; all other behaviour is identical.

Decomposition:
- Shared package sub2_clip_pkg holds:
  - function sat_max(width) and sat_min(width) returning the clip bounds;
  - localparam RAW_W = WIDTH+1 computed in the module from the package helper.
- One natural sub-module: clip_sat (combinational, RAW_W in, WIDTH out, hi/lo flags). It can be reused later by the add-side datapath.
- Counter and sticky logic stay in the top level.

Test Plan:
- WIDTH=16: in1=100, in2=30, strobe 1 cycle -> 2 cycles later strobe_out=1 for 1 cycle, diff=70, clip_hi=clip_lo=0; diff holds 70 afterwards.
- in1=0x7FFF, in2=0x8000 -> diff=0x7FFF, clip_hi=1, clip_sticky=1 one edge later, clip_cnt=1. Then in1=0x8000, in2=0x0001 -> diff=0x8000, clip_lo=1, clip_cnt=2.
- Boundary: in1=0x7FFE, in2=0xFFFF (-1) -> diff=0x7FFF with clip_hi=0; in1=0x8000, in2=0 -> diff=0x8000 with clip_lo=0.
- 8 back-to-back strobes of ramping values -> 8 consecutive strobe_out pulses, each diff matching the reference model at latency 2. Assert rst on the 5th input cycle -> no strobe_out for samples still in flight; all outputs 0.
- CNT_WIDTH=2, 5 clipping samples -> clip_cnt goes 1,2,3,3,3. clr asserted coincident with the next clip event -> clip_cnt=1, clip_sticky=1. clr alone -> clip_cnt=0, clip_sticky=0.
- Build without SUB2_CLIP_CNT_EN: repeat the clip scenario -> clip_cnt stays 0; diff, flags and clip_sticky are identical to the enabled build.

Source files
------------

// File: rtl/sub2_and_clip_reg_pkg.sv
// Shared definitions for the subtract-and-clip datapath: clip bound helpers,
// raw (pre-clip) width helper and the clip classification type.
package sub2_clip_pkg;

  typedef enum logic [1:0] {
    CLIP_NONE = 2'd0,
    CLIP_HI   = 2'd1,
    CLIP_LO   = 2'd2
  } clip_e;

  // Width of an exact sum/difference of two signed samples of 'width' bits.
  function automatic int unsigned raw_width(input int unsigned width);
    return width + 1;
  endfunction

  // Largest representable signed value of 'width' bits.
  function automatic longint sat_max(input int unsigned width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  // Smallest representable signed value of 'width' bits.
  function automatic longint sat_min(input int unsigned width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/sub2_and_clip_reg_clip_sat.sv
// Combinational saturator: narrows a signed RAW_W value to WIDTH bits,
// clamping to the signed range and flagging which bound was hit.
module clip_sat
  import sub2_clip_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RAW_W = raw_width(WIDTH)
) (
  input  logic signed [RAW_W-1:0] i_raw,
  output logic        [WIDTH-1:0] o_sat,
  output logic                    o_hi,
  output logic                    o_lo
);

  localparam logic signed [RAW_W-1:0] MAX_RAW = RAW_W'(sat_max(WIDTH));
  localparam logic signed [RAW_W-1:0] MIN_RAW = RAW_W'(sat_min(WIDTH));
  localparam logic        [WIDTH-1:0] MAX_OUT = WIDTH'(sat_max(WIDTH));
  localparam logic        [WIDTH-1:0] MIN_OUT = WIDTH'(sat_min(WIDTH));

  clip_e w_kind;

  // Classify the raw value against the signed WIDTH-bit range.
  always_comb begin
    w_kind = CLIP_NONE;
    if (i_raw > MAX_RAW) begin
      w_kind = CLIP_HI;
    end else if (i_raw < MIN_RAW) begin
      w_kind = CLIP_LO;
    end
  end

  // Select the clamped value and the matching flag.
  always_comb begin
    o_sat = i_raw[WIDTH-1:0];
    o_hi  = 1'b0;
    o_lo  = 1'b0;
    case (w_kind)
      CLIP_HI: begin
        o_sat = MAX_OUT;
        o_hi  = 1'b1;
      end
      CLIP_LO: begin
        o_sat = MIN_OUT;
        o_lo  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sub2_and_clip_reg.sv
// Registered, strobe-qualified saturating subtractor: diff = clip(in1 - in2).
// Two-stage pipeline (exact difference, then clip), per-sample hi/lo clip
// flags, a sticky clip flag and a saturating clip event counter.
// Optional feature macro: SUB2_CLIP_CNT_EN enables the clip_cnt counter;
// without it clip_cnt is tied to zero and the port list is unchanged.
module sub2_and_clip_reg
  import sub2_clip_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic                 strobe_in,
  input  logic                 clr,
  output logic [WIDTH-1:0]     diff,
  output logic                 strobe_out,
  output logic                 clip_hi,
  output logic                 clip_lo,
  output logic                 clip_sticky,
  output logic [CNT_WIDTH-1:0] clip_cnt
);

  localparam int unsigned RAW_W = raw_width(WIDTH);

  logic signed [RAW_W-1:0] r_raw;
  logic                    r_v1;
  logic [WIDTH-1:0]        r_diff;
  logic                    r_strobe_out;
  logic                    r_clip_hi;
  logic                    r_clip_lo;
  logic                    r_sticky;

  logic signed [RAW_W-1:0] w_raw_next;
  logic [WIDTH-1:0]        w_sat;
  logic                    w_sat_hi;
  logic                    w_sat_lo;
  logic                    w_clip_event;

  // Exact difference: both operands sign-extended by one bit cannot wrap.
  always_comb begin
    w_raw_next = $signed({in1[WIDTH-1], in1}) - $signed({in2[WIDTH-1], in2});
  end

  // Stage 1: capture the exact difference on strobe; raw holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_raw <= '0;
    end else begin
      r_v1 <= strobe_in;
      if (strobe_in) begin
        r_raw <= w_raw_next;
      end
    end
  end

  clip_sat #(
    .WIDTH (WIDTH),
    .RAW_W (RAW_W)
  ) u_clip_sat (
    .i_raw (r_raw),
    .o_sat (w_sat),
    .o_hi  (w_sat_hi),
    .o_lo  (w_sat_lo)
  );

  // Stage 2: register the clipped sample and its flags; diff holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_diff       <= '0;
      r_strobe_out <= 1'b0;
      r_clip_hi    <= 1'b0;
      r_clip_lo    <= 1'b0;
    end else if (r_v1) begin
      r_diff       <= w_sat;
      r_strobe_out <= 1'b1;
      r_clip_hi    <= w_sat_hi;
      r_clip_lo    <= w_sat_lo;
    end else begin
      r_strobe_out <= 1'b0;
      r_clip_hi    <= 1'b0;
      r_clip_lo    <= 1'b0;
    end
  end

  assign w_clip_event = r_strobe_out & (r_clip_hi | r_clip_lo);

  // Sticky clip flag: a clip event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= 1'b0;
    end else if (w_clip_event) begin
      r_sticky <= 1'b1;
    end else if (clr) begin
      r_sticky <= 1'b0;
    end
  end

`ifdef SUB2_CLIP_CNT_EN
  logic [CNT_WIDTH-1:0] r_cnt;

  // Saturating clip event counter; clear with a coincident event loads 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= w_clip_event ? CNT_WIDTH'(1) : '0;
    end else if (w_clip_event && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign clip_cnt = r_cnt;
`else
  assign clip_cnt = '0;
`endif

  assign diff        = r_diff;
  assign strobe_out  = r_strobe_out;
  assign clip_hi     = r_clip_hi;
  assign clip_lo     = r_clip_lo;
  assign clip_sticky = r_sticky;

endmodule

// File: tb/tb_sub2_and_clip_reg.sv
// Self-checking bench for sub2_and_clip_reg (WIDTH=16, CNT_WIDTH=2).
// Expected outputs come from an arithmetic reference: each accepted sample's
// clipped result is computed on entry and delivered two edges later.
module tb_sub2_and_clip_reg;

  localparam int W  = 16;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef SUB2_CLIP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in1 = '0;
  logic [W-1:0]  in2 = '0;
  logic          strobe_in = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  diff;
  logic          strobe_out;
  logic          clip_hi;
  logic          clip_lo;
  logic          clip_sticky;
  logic [CW-1:0] clip_cnt;

  sub2_and_clip_reg #(
    .WIDTH     (W),
    .CNT_WIDTH (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in1         (in1),
    .in2         (in2),
    .strobe_in   (strobe_in),
    .clr         (clr),
    .diff        (diff),
    .strobe_out  (strobe_out),
    .clip_hi     (clip_hi),
    .clip_lo     (clip_lo),
    .clip_sticky (clip_sticky),
    .clip_cnt    (clip_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // ---------------- reference model ----------------
  typedef struct {
    bit         v;
    logic [W-1:0] d;
    bit         hi;
    bit         lo;
  } samp_t;

  samp_t        pend;
  bit           m_strobe, m_hi, m_lo, m_sticky;
  logic [W-1:0] m_diff;
  int           m_cnt;

  function automatic samp_t ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input bit v);
    longint d, mx, mn;
    samp_t r;
    mx = (longint'(1) << (W - 1)) - 1;
    mn = -mx - 1;
    d  = longint'($signed(a)) - longint'($signed(b));
    r.v  = v;
    r.hi = (d > mx);
    r.lo = (d < mn);
    if (d > mx)      r.d = W'(mx);
    else if (d < mn) r.d = W'(mn);
    else             r.d = W'(d);
    return r;
  endfunction

  function automatic logic [CW-1:0] exp_cnt();
    return CNT_EN ? CW'(m_cnt) : '0;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return W'(16'h7FF0 + $urandom_range(0, 15));
      1:       return W'(16'h8000 + $urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic drive_cycle(input bit r, input bit s, input logic [W-1:0] a,
                             input logic [W-1:0] b, input bit c);
    bit ev;
    rst = r; strobe_in = s; in1 = a; in2 = b; clr = c;
    @(posedge clk);
    if (r) begin
      pend = '{v: 1'b0, d: '0, hi: 1'b0, lo: 1'b0};
      m_strobe = 0; m_hi = 0; m_lo = 0; m_sticky = 0; m_diff = '0; m_cnt = 0;
    end else begin
      ev = m_strobe && (m_hi || m_lo);
      if (ev)     m_sticky = 1;
      else if (c) m_sticky = 0;
      if (c)                      m_cnt = ev ? 1 : 0;
      else if (ev && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_strobe = pend.v;
      m_hi = pend.v && pend.hi;
      m_lo = pend.v && pend.lo;
      if (pend.v) m_diff = pend.d;
      pend = ref_sub(a, b, s);
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 1, W'($urandom), W'($urandom), 1'($urandom));
      n_checks++;
      if ({strobe_out, clip_hi, clip_lo, clip_sticky, clip_cnt, diff} !== '0)
        $display("FAIL reset: outs=%h required 0",
                 {strobe_out, clip_hi, clip_lo, clip_sticky, clip_cnt, diff});
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(0, i == 0, 16'd100, 16'd30, 0);
      n_checks++;
      if ({strobe_out, clip_hi, clip_lo, clip_sticky, clip_cnt, diff} !==
          {m_strobe, m_hi, m_lo, m_sticky, exp_cnt(), m_diff})
        $display("FAIL basic[%0d]: got s=%b hi=%b lo=%b st=%b cnt=%0d d=%h want s=%b hi=%b lo=%b st=%b cnt=%0d d=%h",
                 i, strobe_out, clip_hi, clip_lo, clip_sticky, clip_cnt, diff,
                 m_strobe, m_hi, m_lo, m_sticky, exp_cnt(), m_diff);
      else n_pass++;
      n_checks++;
      if ({strobe_out, diff} !== {(i == 1), (i >= 1) ? 16'd70 : 16'd0})
        $display("FAIL basic_const[%0d]: got s=%b d=%0d want s=%b d=%0d",
                 i, strobe_out, diff, (i == 1), (i >= 1) ? 70 : 0);
      else n_pass++;
    end
  endtask

  task automatic test_clip();
    logic [W-1:0] a, b;
    drive_cycle(0, 0, '0, '0, 1);
    for (int i = 0; i < 5; i++) begin
      a = (i == 0) ? 16'h7FFF : 16'h8000;
      b = (i == 0) ? 16'h8000 : 16'h0001;
      drive_cycle(0, i < 2, a, b, 0);
      n_checks++;
      if ({strobe_out, clip_hi, clip_lo, clip_sticky, clip_cnt, diff} !==
          {m_strobe, m_hi, m_lo, m_sticky, exp_cnt(), m_diff})
        $display("FAIL clip[%0d]: got s=%b hi=%b lo=%b st=%b cnt=%0d d=%h want s=%b hi=%b lo=%b st=%b cnt=%0d d=%h",
                 i, strobe_out, clip_hi, clip_lo, clip_sticky, clip_cnt, diff,
                 m_strobe, m_hi, m_lo, m_sticky, exp_cnt(), m_diff);
      else n_pass++;
      if (i == 1) begin
        n_checks++;
        if ({diff, clip_hi, clip_lo} !== {16'h7FFF, 1'b1, 1'b0})
          $display("FAIL clip_hi_const: got d=%h hi=%b lo=%b want 7fff 1 0", diff, clip_hi, clip_lo);
        else n_pass++;
      end
      if (i == 2) begin
        n_checks++;
        if ({diff, clip_hi, clip_lo, clip_sticky} !== {16'h8000, 1'b0, 1'b1, 1'b1})
          $display("FAIL clip_lo_const: got d=%h hi=%b lo=%b st=%b want 8000 0 1 1",
                   diff, clip_hi, clip_lo, clip_sticky);
        else n_pass++;
      end
      if (i == 3) begin
        n_checks++;
        if (clip_cnt !== (CNT_EN ? CW'(2) : CW'(0)))
          $display("FAIL clip_cnt_const: got %0d want %0d", clip_cnt, CNT_EN ? 2 : 0);
        else n_pass++;
      end
    end
  endtask

  task automatic test_boundary();
    logic [W-1:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 16'h7FFE : 16'h8000;
      b = (i == 0) ? 16'hFFFF : 16'h0000;
      drive_cycle(0, i < 2, a, b, 0);
      if (i == 1 || i == 2) begin
        n_checks++;
        if ({strobe_out, diff, clip_hi, clip_lo} !==
            {1'b1, (i == 1) ? 16'h7FFF : 16'h8000, 1'b0, 1'b0})
          $display("FAIL boundary[%0d]: got s=%b d=%h hi=%b lo=%b want s=1 d=%h no clip",
                   i, strobe_out, diff, clip_hi, clip_lo, (i == 1) ? 16'h7FFF : 16'h8000);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(0, i < 8, W'(32'h7000 + i * 32'h0800), W'(i * 32'h1800), 0);
      if (strobe_out === 1'b1) pulses++;
      n_checks++;
      if ({strobe_out, clip_hi, clip_lo, clip_sticky, clip_cnt, diff} !==
          {m_strobe, m_hi, m_lo, m_sticky, exp_cnt(), m_diff})
        $display("FAIL b2b[%0d]: got s=%b hi=%b lo=%b st=%b cnt=%0d d=%h want s=%b hi=%b lo=%b st=%b cnt=%0d d=%h",
                 i, strobe_out, clip_hi, clip_lo, clip_sticky, clip_cnt, diff,
                 m_strobe, m_hi, m_lo, m_sticky, exp_cnt(), m_diff);
      else n_pass++;
    end
    n_checks++;
    if (pulses != 8) $display("FAIL b2b_pulses: got %0d want 8", pulses);
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(i == 4, i <= 4, W'(32'h7F00 + i), W'(32'h8000 - i), 0);
      if (i >= 4) begin
        n_checks++;
        if ({strobe_out, clip_hi, clip_lo, clip_sticky, clip_cnt, diff} !== '0)
          $display("FAIL rst_inflight[%0d]: outs=%h required 0", i,
                   {strobe_out, clip_hi, clip_lo, clip_sticky, clip_cnt, diff});
        else n_pass++;
      end
    end
  endtask

  task automatic test_cnt_sat();
    logic [CW-1:0] seq [5];
    logic [CW-1:0] want;
    seq = '{CW'(1), CW'(2), CW'(3), CW'(3), CW'(3)};
    drive_cycle(0, 0, '0, '0, 1);
    for (int i = 0; i < 11; i++) begin
      drive_cycle(0, (i < 5) || (i == 7), 16'h7FFF, 16'hFF00, i >= 9);
      n_checks++;
      if ({strobe_out, clip_hi, clip_lo, clip_sticky, clip_cnt, diff} !==
          {m_strobe, m_hi, m_lo, m_sticky, exp_cnt(), m_diff})
        $display("FAIL cnt[%0d]: got s=%b hi=%b lo=%b st=%b cnt=%0d d=%h want s=%b hi=%b lo=%b st=%b cnt=%0d d=%h",
                 i, strobe_out, clip_hi, clip_lo, clip_sticky, clip_cnt, diff,
                 m_strobe, m_hi, m_lo, m_sticky, exp_cnt(), m_diff);
      else n_pass++;
      if (i >= 2 && i <= 6) begin
        want = CNT_EN ? seq[i-2] : '0;
        n_checks++;
        if (clip_cnt !== want) $display("FAIL cnt_sat[%0d]: got %0d want %0d", i, clip_cnt, want);
        else n_pass++;
      end
      if (i == 9 || i == 10) begin
        want = (CNT_EN && i == 9) ? CW'(1) : CW'(0);
        n_checks++;
        if ({clip_cnt, clip_sticky} !== {want, (i == 9)})
          $display("FAIL cnt_clr[%0d]: got cnt=%0d st=%b want cnt=%0d st=%b",
                   i, clip_cnt, clip_sticky, want, (i == 9));
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive_cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                  rnd_val(), rnd_val(), $urandom_range(0, 9) == 0);
      n_checks++;
      if ({strobe_out, clip_hi, clip_lo, clip_sticky, clip_cnt, diff} !==
          {m_strobe, m_hi, m_lo, m_sticky, exp_cnt(), m_diff})
        $display("FAIL random[%0d]: got s=%b hi=%b lo=%b st=%b cnt=%0d d=%h want s=%b hi=%b lo=%b st=%b cnt=%0d d=%h",
                 i, strobe_out, clip_hi, clip_lo, clip_sticky, clip_cnt, diff,
                 m_strobe, m_hi, m_lo, m_sticky, exp_cnt(), m_diff);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_boundary();
    test_back_to_back();
    test_reset_inflight();
    test_cnt_sat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
